// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and default widths for the request-bus to generic_sync_mem bridge.
package mem_bus_bridge_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_bus_bridge.sv
// Bridges a valid/ready request bus onto generic_sync_mem strobes with a registered read response.
// Optional MEM_BUS_BRIDGE_BURST_EN adds req_len for incrementing read bursts.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
`ifdef MEM_BUS_BRIDGE_BURST_EN
    input  logic [3:0]        req_len,
`endif
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_t            state, state_n;
    logic              cs_n, we_n, oe_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n, rdata_n;
`ifdef MEM_BUS_BRIDGE_BURST_EN
    logic [3:0]        beats_left, beats_n;
`endif

    // Held low during reset so nothing is accepted until rst drops.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_n = state;
        cs_n    = 1'b0;
        we_n    = 1'b0;
        oe_n    = 1'b0;
        addr_n  = mem_address;
        din_n   = mem_data_in;
        rdata_n = rsp_rdata;
`ifdef MEM_BUS_BRIDGE_BURST_EN
        beats_n = beats_left;
`endif
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cs_n   = 1'b1;
                    addr_n = req_addr;
                    if (req_we) begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        din_n   = req_wdata;
`ifdef MEM_BUS_BRIDGE_BURST_EN
                        beats_n = 4'd0;
`endif
                    end else begin
                        state_n = READ;
                        oe_n    = 1'b1;
`ifdef MEM_BUS_BRIDGE_BURST_EN
                        beats_n = req_len;
`endif
                    end
                end
            end
            WRITE:   state_n = IDLE;
            READ:    state_n = CAPTURE;
            CAPTURE: begin
                // Memory output is valid now, one cycle after the cs&oe strobe.
                rdata_n = mem_data_out;
                state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
`ifdef MEM_BUS_BRIDGE_BURST_EN
                    if (beats_left != 4'd0) begin
                        beats_n = beats_left - 4'd1;
                        state_n = READ;
                        cs_n    = 1'b1;
                        oe_n    = 1'b1;
                        addr_n  = mem_address + ADDR_W'(1);
                    end else begin
                        state_n = IDLE;
                    end
`else
                    state_n = IDLE;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rsp_rdata   <= '0;
`ifdef MEM_BUS_BRIDGE_BURST_EN
            beats_left  <= 4'd0;
`endif
        end else begin
            state       <= state_n;
            mem_cs      <= cs_n;
            mem_we      <= we_n;
            mem_oe      <= oe_n;
            mem_address <= addr_n;
            mem_data_in <= din_n;
            rsp_rdata   <= rdata_n;
`ifdef MEM_BUS_BRIDGE_BURST_EN
            beats_left  <= beats_n;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: vector table, read scoreboard, corner sequences.
module tb_mem_bus_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic       mem_cs, mem_we, mem_oe;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
`ifdef MEM_BUS_BRIDGE_BURST_EN
    logic [3:0] req_len;
`endif

    mem_bus_bridge #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
`ifdef MEM_BUS_BRIDGE_BURST_EN
        .req_len(req_len),
`endif
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // generic_sync_mem model: read data appears one cycle after cs&oe.
    logic [7:0] mem_arr [256];
    always @(posedge clk) begin
        if (mem_cs && mem_we) mem_arr[mem_address] <= mem_data_in;
        if (mem_cs && mem_oe) mem_data_out <= mem_arr[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected read data, consumed on each response handshake.
    logic [7:0] sbq [$];
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got 0x%0h expected no response", rsp_rdata);
            end else begin
                chk("rsp_rdata", rsp_rdata, sbq.pop_front());
            end
        end
    end

    // Bus hygiene and strobe capture.
    int         viol = 0;
    int         cs_cnt = 0;
    logic       last_we, last_oe;
    logic [7:0] last_addr;
    always @(negedge clk) begin
        if (mem_we && mem_oe) viol++;
        if (rsp_valid && (mem_cs || mem_we || mem_oe)) viol++;
        if (mem_cs) begin
            cs_cnt++;
            last_we   = mem_we;
            last_oe   = mem_oe;
            last_addr = mem_address;
        end
    end

    task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [3:0] len, output int acc);
        logic ok;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
`ifdef MEM_BUS_BRIDGE_BURST_EN
        req_len   = len;
`else
        if (len != 4'd0) $display("note: req_len ignored in single-beat build");
`endif
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        acc = cyc;
        if (!ok) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        int         gap;
    } vec_t;
    vec_t vecs [8];

    initial begin
        int acc, prev, n;
        logic ok;

        vecs[0] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
        vecs[1] = '{1'b1, 8'h01, 8'hBB, 8'h00, 2};
        vecs[2] = '{1'b1, 8'h02, 8'hCC, 8'h00, 2};
        vecs[3] = '{1'b1, 8'h03, 8'hDD, 8'h00, 2};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 2};
        vecs[5] = '{1'b0, 8'h01, 8'h00, 8'hBB, 4};
        vecs[6] = '{1'b0, 8'h02, 8'h00, 8'hCC, 4};
        vecs[7] = '{1'b0, 8'h03, 8'h00, 8'hDD, 4};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
`ifdef MEM_BUS_BRIDGE_BURST_EN
        req_len = 4'd0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_strobes", {mem_cs, mem_we, mem_oe}, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        // Writes then reads, with accept-to-accept spacing checked.
        @(posedge clk); #1;
        prev = 0;
        foreach (vecs[i]) begin
            if (!vecs[i].we) sbq.push_back(vecs[i].exp);
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, 4'd0, acc);
            if (vecs[i].gap > 0) chk($sformatf("accept_gap[%0d]", i), acc - prev, vecs[i].gap);
            prev = acc;
        end
        repeat (8) @(negedge clk);
        chk("table_drained", sbq.size(), 0);

        // Single write strobe.
        cs_cnt = 0;
        @(posedge clk); #1;
        issue(1'b1, 8'h10, 8'h5A, 4'd0, acc);
        repeat (4) @(negedge clk);
        chk("wr_cs_cycles", cs_cnt, 1);
        chk("wr_we", last_we, 1);
        chk("wr_oe", last_oe, 0);
        chk("wr_addr", last_addr, 8'h10);

        // Read held off by rsp_ready=0.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        sbq.push_back(8'hBB);
        issue(1'b0, 8'h01, 8'h00, 4'd0, acc);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_latency", ok ? n : 0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, 8'hBB);
            chk("hold_req_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_idle_after", req_ready, 1);
        chk("hold_drained", sbq.size(), 0);

        // Reset during a read drops the response.
        @(posedge clk); #1;
        sbq.push_back(8'hCC);
        issue(1'b0, 8'h02, 8'h00, 4'd0, acc);
        @(negedge clk);
        chk("abort_in_read", {mem_cs, mem_oe, mem_we}, 3'b110);
        #1;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("abort_strobes", {mem_cs, mem_we, mem_oe}, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        chk("abort_no_rsp", n, 0);
        @(posedge clk); #1;
        sbq.push_back(8'hDD);
        issue(1'b0, 8'h03, 8'h00, 4'd0, acc);
        repeat (6) @(negedge clk);
        chk("after_abort_drained", sbq.size(), 0);

`ifdef MEM_BUS_BRIDGE_BURST_EN
        // Wrapping burst read across the top of the address space.
        @(posedge clk); #1;
        issue(1'b1, 8'hFE, 8'h11, 4'd0, acc);
        issue(1'b1, 8'hFF, 8'h22, 4'd0, acc);
        sbq.push_back(8'h11);
        sbq.push_back(8'h22);
        sbq.push_back(8'hFF);
        sbq.push_back(8'hBB);
        issue(1'b0, 8'hFE, 8'h00, 4'd3, acc);
        repeat (24) @(negedge clk);
        chk("burst_drained", sbq.size(), 0);
        chk("burst_idle", req_ready, 1);
`endif

        chk("bus_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter: ADDR_W, default 8, address width in bits.
REQ-002 Parameter: DATA_W, default 8, data width in bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  bridge accepts a request this cycle.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  request address.
REQ-009 req_wdata  in  DATA_W  write data.
REQ-010 rsp_valid  out  1  read data available.
REQ-011 rsp_ready  in  1  consumer takes read data.
REQ-012 rsp_rdata  out  DATA_W  read data, registered.
REQ-013 mem_cs, mem_we, mem_oe  out  1 each  strobes to the downstream generic_sync_mem.
REQ-014 mem_address  out  ADDR_W; mem_data_in  out  DATA_W; mem_data_out  in  DATA_W (valid one cycle after a cs&oe strobe).

Function
REQ-015 FSM states SHALL be IDLE, WRITE, READ, CAPTURE and RESP; all mem_* outputs SHALL be registered.
REQ-016 req_ready SHALL be 1 only in IDLE; a transfer occurs on req_valid & req_ready at a rising edge E0.
REQ-017 Write: IDLE->WRITE at E0; during WRITE cs=1, we=1, oe=0, address/data_in = captured req_addr/req_wdata; WRITE->IDLE at E1.
REQ-018 Read: IDLE->READ at E0; during READ cs=1, oe=1, we=0, address = req_addr; READ->CAPTURE at E1.
REQ-019 In CAPTURE, all strobes SHALL be 0; mem_data_out SHALL be latched into rsp_rdata at E2; CAPTURE->RESP.
REQ-020 In RESP, rsp_valid SHALL be 1 and rsp_rdata stable until rsp_valid & rsp_ready; then RESP->IDLE at that edge.
REQ-021 Minimum latency: write = 2 cycles per request; read = rsp_valid 2 cycles after E0; back-to-back read issue rate of one per 4 cycles with rsp_ready held high.
REQ-022 mem_cs=mem_we=mem_oe=0 in IDLE, CAPTURE and RESP; we and oe SHALL never both be 1.
REQ-023 Request inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.

Reset
REQ-024 While rst=1: FSM=IDLE; mem_cs, mem_we, mem_oe, rsp_valid = 0; mem_address, mem_data_in, rsp_rdata = 0; req_ready = 0.
REQ-025 Reset asserted mid-transaction SHALL abort it immediately, dropping any pending response; after release, req_ready=1 in the first cycle.

Configuration
REQ-026 Macro MEM_BUS_BRIDGE_BURST_EN SHALL, when defined, add input req_len[3:0]; a read of length L yields L+1 responses at req_addr, req_addr+1, ..., each as REQ-018..020, with the address wrapping modulo 2^ADDR_W; req_ready stays 0 until the last response is taken.
REQ-027 Without MEM_BUS_BRIDGE_BURST_EN, req_len SHALL NOT exist and every read yields exactly one response; writes are single-beat in both builds.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef and the ADDR_W/DATA_W default constants.
REQ-029 No sub-module is required; the burst counter SHALL be inline logic under the macro.

Verification
REQ-030 Writes 0x00<-0xFF, 0x01<-0xBB, 0x02<-0xCC, 0x03<-0xDD with a generic_sync_mem model; then reads of 0x00..0x03 -> rsp_rdata 0xFF, 0xBB, 0xCC, 0xDD in order.
REQ-031 Read of 0x01 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_rdata=0xBB stable, req_ready=0 throughout, then IDLE after handshake.
REQ-032 Write to 0x10 -> exactly one cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_address=0x10; never we&oe together.
REQ-033 rst pulsed during READ of 0x02 -> all strobes 0, rsp_valid 0, no response produced, next request served normally.
REQ-034 BURST_EN build, read with req_addr=0xFE and req_len=3 -> responses from 0xFE, 0xFF, 0x00, 0x01 in order.
